drive_cmd_arbiter: RTL and testbench

//  Sits between the mode FSM and the motor driver. It selects the drive command source:

---
 rtl/drive_cmd_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_drive_cmd_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/drive_cmd_arbiter.sv
// Drive command arbiter: picks CAM or IR drive source, enforces hold/gap timing,
// IR watchdog and estop override; registered drive code to the motor driver.
//
// Ports:
//   clk_50, reset_n       clock, async active-low reset
//   mode[1:0]             00 IDLE, 01 CAM, 10 IR, 11 IDLE
//   cam_valid, cam_cmd    camera request
//   ir_valid, ir_cmd      IR command pulse
//   estop                 forces STOP while high
//   cmd_out, cmd_valid    registered drive code, change pulse
//   grant                 owning source (00 none, 01 CAM, 10 IR)
//   busy                  high during the STOP gap
//   ir_timeout            IR watchdog expired
module drive_cmd_arbiter #(
    parameter int HOLD_CYCLES    = 2_500_000,
    parameter int GAP_CYCLES     = 500_000,
    parameter int TIMEOUT_CYCLES = 25_000_000
) (
    input  logic       clk_50,
    input  logic       reset_n,
    input  logic [1:0] mode,
    input  logic       cam_valid,
    input  logic [2:0] cam_cmd,
    input  logic       ir_valid,
    input  logic [2:0] ir_cmd,
    input  logic       estop,
    output logic [2:0] cmd_out,
    output logic       cmd_valid,
    output logic [1:0] grant,
    output logic       busy,
    output logic       ir_timeout
);

    localparam logic [2:0] STOP  = 3'b000;
    localparam logic [2:0] LEFT  = 3'b001;
    localparam logic [2:0] RIGHT = 3'b010;
    localparam logic [2:0] SLOW  = 3'b011;
    localparam logic [2:0] FAST  = 3'b101;

    localparam logic [1:0] SRC_NONE = 2'b00;
    localparam logic [1:0] SRC_CAM  = 2'b01;
    localparam logic [1:0] SRC_IR   = 2'b10;

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_STOPPED,
        ST_DRIVE,
        ST_GAP
    } state_t;

    state_t state, state_nxt;

    logic [2:0]    ir_latch;
    logic [TW-1:0] wd_cnt;
    logic [HW-1:0] hold_cnt, hold_nxt;
    logic [GW-1:0] gap_cnt, gap_nxt;
    logic [2:0]    cmd_nxt;
    logic [1:0]    grant_nxt;
    logic [2:0]    target;
    logic [1:0]    tsrc;
    logic          hold_done, gap_done, conflict;

    // Reserved codes 110/111 are treated as STOP.
    function automatic logic [2:0] norm(input logic [2:0] c);
        return (c > FAST) ? STOP : c;
    endfunction

    function automatic logic is_turn(input logic [2:0] c);
        return (c == LEFT) || (c == RIGHT);
    endfunction

    // IR latch and watchdog; a fresh ir_valid beats expiry on the same cycle.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            ir_latch   <= STOP;
            wd_cnt     <= '0;
            ir_timeout <= 1'b1;
        end else if (ir_valid) begin
            ir_latch   <= norm(ir_cmd);
            wd_cnt     <= '0;
            ir_timeout <= 1'b0;
        end else if (wd_cnt == TO_LAST) begin
            ir_latch   <= STOP;
            ir_timeout <= 1'b1;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    always_comb begin
        target = STOP;
        tsrc   = SRC_NONE;
        unique case (1'b1)
            (mode == SRC_CAM): begin
                tsrc   = SRC_CAM;
                target = cam_valid ? norm(cam_cmd) : STOP;
            end
            (mode == SRC_IR): begin
                tsrc   = SRC_IR;
                target = ir_latch;
            end
            default: ;
        endcase
    end

    assign hold_done = (hold_cnt == HOLD_LAST);
    assign gap_done  = (gap_cnt == GAP_LAST);

    // Both codes are non-STOP in DRIVE, so a class change is a turn/fwd flip.
    assign conflict = (is_turn(target) != is_turn(cmd_out))
                   || (is_turn(target) && is_turn(cmd_out)
                       && (target != cmd_out))
                   || (tsrc != grant);

    // State register and registered outputs.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_STOPPED;
            cmd_out   <= STOP;
            cmd_valid <= 1'b0;
            grant     <= SRC_NONE;
            busy      <= 1'b0;
            hold_cnt  <= '0;
            gap_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            cmd_out   <= cmd_nxt;
            cmd_valid <= (cmd_nxt != cmd_out);
            grant     <= grant_nxt;
            busy      <= (state_nxt == ST_GAP);
            hold_cnt  <= hold_nxt;
            gap_cnt   <= gap_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_STOPPED: begin
                if (target != STOP && !estop)
                    state_nxt = ST_DRIVE;
            end
            ST_DRIVE: begin
                if (estop)
                    state_nxt = ST_STOPPED;
                else if (tsrc != grant)
                    state_nxt = ST_GAP;
                else if (target == cmd_out || !hold_done)
                    state_nxt = ST_DRIVE;
                else if (target == STOP)
                    state_nxt = ST_STOPPED;
                else if (conflict)
                    state_nxt = ST_GAP;
            end
            ST_GAP: begin
                if (estop)
                    state_nxt = ST_STOPPED;
                else if (gap_done)
                    state_nxt = (target != STOP) ? ST_DRIVE : ST_STOPPED;
            end
            default: state_nxt = ST_STOPPED;
        endcase
    end

    // Output / counter next values.
    always_comb begin
        cmd_nxt   = STOP;
        grant_nxt = SRC_NONE;
        hold_nxt  = '0;
        gap_nxt   = '0;
        unique case (state_nxt)
            ST_DRIVE: begin
                if (state != ST_DRIVE || (hold_done && target != cmd_out)) begin
                    // Fresh entry, or a same-class speed change after hold.
                    cmd_nxt   = target;
                    grant_nxt = tsrc;
                end else begin
                    cmd_nxt   = cmd_out;
                    grant_nxt = grant;
                    hold_nxt  = hold_done ? hold_cnt : hold_cnt + 1'b1;
                end
            end
            ST_GAP: begin
                gap_nxt = (state == ST_GAP) ? gap_cnt + 1'b1 : '0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_drive_cmd_arbiter.sv
// Directed bench for drive_cmd_arbiter with short hold/gap/timeout values.
// Observed bundle is {cmd_out, cmd_valid, grant, busy}.
module tb_drive_cmd_arbiter;

    logic       clk_50 = 1'b0;
    logic       reset_n;
    logic [1:0] mode;
    logic       cam_valid;
    logic [2:0] cam_cmd;
    logic       ir_valid;
    logic [2:0] ir_cmd;
    logic       estop;
    logic [2:0] cmd_out;
    logic       cmd_valid;
    logic [1:0] grant;
    logic       busy;
    logic       ir_timeout;

    int checks = 0;
    int errors = 0;
    logic [6:0] obs, exp;

    drive_cmd_arbiter #(
        .HOLD_CYCLES(4),
        .GAP_CYCLES(3),
        .TIMEOUT_CYCLES(10)
    ) dut (
        .clk_50(clk_50),
        .reset_n(reset_n),
        .mode(mode),
        .cam_valid(cam_valid),
        .cam_cmd(cam_cmd),
        .ir_valid(ir_valid),
        .ir_cmd(ir_cmd),
        .estop(estop),
        .cmd_out(cmd_out),
        .cmd_valid(cmd_valid),
        .grant(grant),
        .busy(busy),
        .ir_timeout(ir_timeout)
    );

    always #5 clk_50 = ~clk_50;

    task automatic tick;
        @(posedge clk_50);
        #1;
    endtask

    task automatic do_reset;
        mode = 2'b00; cam_valid = 1'b0; cam_cmd = 3'd0;
        ir_valid = 1'b0; ir_cmd = 3'd0; estop = 1'b0;
        reset_n = 1'b0;
        tick;
        tick;
        reset_n = 1'b1;
    endtask

    task automatic test_reset;
        mode = 2'b00; cam_valid = 1'b0; cam_cmd = 3'd0;
        ir_valid = 1'b0; ir_cmd = 3'd0; estop = 1'b0;
        reset_n = 1'b0;
        tick;
        obs = {cmd_out, cmd_valid, grant, busy};
        exp = {3'd0, 1'b0, 2'b00, 1'b0};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL rst_outs got %b want %b", obs, exp);
        end
        checks++;
        if (ir_timeout !== 1'b1) begin
            errors++;
            $display("FAIL rst_irto got %b want 1", ir_timeout);
        end
        reset_n = 1'b1;
        // reserved code 111 must behave as STOP
        mode = 2'b01; cam_valid = 1'b1; cam_cmd = 3'b111;
        tick;
        obs = {cmd_out, cmd_valid, grant, busy};
        exp = {3'd0, 1'b0, 2'b00, 1'b0};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL rst_release got %b want %b", obs, exp);
        end
        tick;
        obs = {cmd_out, cmd_valid, grant, busy};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL code111 got %b want %b", obs, exp);
        end
    endtask

    task automatic test_cam_left;
        do_reset;
        mode = 2'b01; cam_valid = 1'b1; cam_cmd = 3'd1;
        tick;
        obs = {cmd_out, cmd_valid, grant, busy};
        exp = {3'd1, 1'b1, 2'b01, 1'b0};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL left_start got %b want %b", obs, exp);
        end
        tick;
        obs = {cmd_out, cmd_valid, grant, busy};
        exp = {3'd1, 1'b0, 2'b01, 1'b0};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL left_pulse got %b want %b", obs, exp);
        end
    endtask

    // continues from LEFT held for 2 cycles
    task automatic test_turn_gap;
        logic [6:0] want [6];
        want[0] = {3'd1, 1'b0, 2'b01, 1'b0};
        want[1] = {3'd1, 1'b0, 2'b01, 1'b0};
        want[2] = {3'd0, 1'b1, 2'b00, 1'b1};
        want[3] = {3'd0, 1'b0, 2'b00, 1'b1};
        want[4] = {3'd0, 1'b0, 2'b00, 1'b1};
        want[5] = {3'd2, 1'b1, 2'b01, 1'b0};
        cam_cmd = 3'd2;
        for (int i = 0; i < 6; i++) begin
            tick;
            obs = {cmd_out, cmd_valid, grant, busy};
            checks++;
            if (obs !== want[i]) begin
                errors++;
                $display("FAIL turn_gap[%0d] got %b want %b",
                         i, obs, want[i]);
            end
        end
    endtask

    task automatic test_speed_change;
        do_reset;
        mode = 2'b01; cam_valid = 1'b1; cam_cmd = 3'd3;
        tick;
        tick;
        tick;
        cam_cmd = 3'd5;
        tick;
        obs = {cmd_out, cmd_valid, grant, busy};
        exp = {3'd3, 1'b0, 2'b01, 1'b0};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL speed_hold got %b want %b", obs, exp);
        end
        tick;
        obs = {cmd_out, cmd_valid, grant, busy};
        exp = {3'd5, 1'b1, 2'b01, 1'b0};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL speed_fast got %b want %b", obs, exp);
        end
        tick;
        obs = {cmd_out, cmd_valid, grant, busy};
        exp = {3'd5, 1'b0, 2'b01, 1'b0};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL speed_nogap got %b want %b", obs, exp);
        end
    endtask

    task automatic test_ir_timeout;
        do_reset;
        mode = 2'b10; ir_valid = 1'b1; ir_cmd = 3'd4;
        tick;
        ir_valid = 1'b0;
        checks++;
        if (ir_timeout !== 1'b0) begin
            errors++;
            $display("FAIL ir_load_to got %b want 0", ir_timeout);
        end
        tick;
        obs = {cmd_out, cmd_valid, grant, busy};
        exp = {3'd4, 1'b1, 2'b10, 1'b0};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL ir_medium got %b want %b", obs, exp);
        end
        repeat (8) tick;
        obs = {cmd_out, cmd_valid, grant, busy};
        exp = {3'd4, 1'b0, 2'b10, 1'b0};
        checks++;
        if (obs !== exp || ir_timeout !== 1'b0) begin
            errors++;
            $display("FAIL ir_pre_to got %b/%b want %b/0",
                     obs, ir_timeout, exp);
        end
        tick;
        checks++;
        if (obs !== {cmd_out, cmd_valid, grant, busy} || ir_timeout !== 1'b1) begin
            errors++;
            $display("FAIL ir_expire got %b/%b want %b/1",
                     {cmd_out, cmd_valid, grant, busy}, ir_timeout, exp);
        end
        tick;
        obs = {cmd_out, cmd_valid, grant, busy};
        exp = {3'd0, 1'b1, 2'b00, 1'b0};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL ir_stop got %b want %b", obs, exp);
        end
    endtask

    task automatic test_estop;
        do_reset;
        mode = 2'b01; cam_valid = 1'b1; cam_cmd = 3'd5;
        tick;
        tick;
        estop = 1'b1;
        tick;
        obs = {cmd_out, cmd_valid, grant, busy};
        exp = {3'd0, 1'b1, 2'b00, 1'b0};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL estop_stop got %b want %b", obs, exp);
        end
        tick;
        obs = {cmd_out, cmd_valid, grant, busy};
        exp = {3'd0, 1'b0, 2'b00, 1'b0};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL estop_held got %b want %b", obs, exp);
        end
        estop = 1'b0;
        tick;
        obs = {cmd_out, cmd_valid, grant, busy};
        exp = {3'd5, 1'b1, 2'b01, 1'b0};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL estop_resume got %b want %b", obs, exp);
        end
    endtask

    task automatic test_mode_switch;
        logic [6:0] want [4];
        want[0] = {3'd0, 1'b1, 2'b00, 1'b1};
        want[1] = {3'd0, 1'b0, 2'b00, 1'b1};
        want[2] = {3'd0, 1'b0, 2'b00, 1'b1};
        want[3] = {3'd2, 1'b1, 2'b10, 1'b0};
        do_reset;
        mode = 2'b01; cam_valid = 1'b1; cam_cmd = 3'd1;
        ir_valid = 1'b1; ir_cmd = 3'd2;
        tick;
        ir_valid = 1'b0;
        obs = {cmd_out, cmd_valid, grant, busy};
        exp = {3'd1, 1'b1, 2'b01, 1'b0};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL sw_left got %b want %b", obs, exp);
        end
        mode = 2'b10;
        for (int i = 0; i < 4; i++) begin
            tick;
            obs = {cmd_out, cmd_valid, grant, busy};
            checks++;
            if (obs !== want[i]) begin
                errors++;
                $display("FAIL sw_gap[%0d] got %b want %b",
                         i, obs, want[i]);
            end
        end
        mode = 2'b01;
        tick;
        obs = {cmd_out, cmd_valid, grant, busy};
        exp = {3'd0, 1'b1, 2'b00, 1'b1};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL sw_back_gap got %b want %b", obs, exp);
        end
        reset_n = 1'b0;
        #1;
        obs = {cmd_out, cmd_valid, grant, busy};
        exp = {3'd0, 1'b0, 2'b00, 1'b0};
        checks++;
        if (obs !== exp || ir_timeout !== 1'b1) begin
            errors++;
            $display("FAIL async_rst got %b/%b want %b/1",
                     obs, ir_timeout, exp);
        end
        tick;
        reset_n = 1'b1;
        tick;
        obs = {cmd_out, cmd_valid, grant, busy};
        exp = {3'd1, 1'b1, 2'b01, 1'b0};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL post_rst got %b want %b", obs, exp);
        end
    endtask

    initial begin
        test_reset;
        test_cam_left;
        test_turn_gap;
        test_speed_change;
        test_ir_timeout;
        test_estop;
        test_mode_switch;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
